// File: rtl/mips_debug_unit.sv
// Debug controller for the five-stage MIPS pipeline: runs or single-steps the core via a clock-enable,
// then snapshots the pipeline latches plus an executed-cycle counter and streams them MSB byte first to a UART.
module mips_debug_unit #(
    parameter int               NB_DATA   = 8,
    parameter int               NB_IF_ID  = 64,
    parameter int               NB_ID_EX  = 192,
    parameter int               NB_EX_MEM = 128,
    parameter int               NB_MEM_WB = 64,
    parameter int               NB_CYCLES = 32,
    parameter logic [NB_DATA-1:0] CMD_RUN  = 8'h43,
    parameter logic [NB_DATA-1:0] CMD_STEP = 8'h53,
    parameter logic [NB_DATA-1:0] CMD_DUMP = 8'h44,
    parameter logic [NB_DATA-1:0] CMD_STOP = 8'h50
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_tx_done,
    input  logic                 i_halt,
    input  logic [NB_IF_ID-1:0]  i_if_id,
    input  logic [NB_ID_EX-1:0]  i_id_ex,
    input  logic [NB_EX_MEM-1:0] i_ex_mem,
    input  logic [NB_MEM_WB-1:0] i_mem_wb,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_mips_enable,
    output logic                 o_busy
);

    localparam int SNAP_W   = NB_CYCLES + NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam int NB_BYTES = SNAP_W / NB_DATA;
    localparam int IDX_W    = $clog2(NB_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        CAPTURE,
        SEND,
        WAIT_TX
    } state_t;

    state_t              state;
    logic [NB_CYCLES-1:0] cycles;
    logic [SNAP_W-1:0]    snapshot;
    logic [IDX_W-1:0]     byte_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cycles        <= '0;
            snapshot      <= '0;
            byte_idx      <= '0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_mips_enable <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            if (o_mips_enable) begin
                cycles <= cycles + NB_CYCLES'(1);
            end

            case (state)
                IDLE: begin
                    if (i_rx_done) begin
                        if (i_rx_data == CMD_RUN) begin
                            state         <= RUN;
                            o_mips_enable <= 1'b1;
                            o_busy        <= 1'b1;
                        end else if (i_rx_data == CMD_STEP) begin
                            state         <= STEP;
                            o_mips_enable <= 1'b1;
                            o_busy        <= 1'b1;
                        end else if (i_rx_data == CMD_DUMP) begin
                            state  <= CAPTURE;
                            o_busy <= 1'b1;
                        end
                    end
                end

                // The pipeline still advances on the edge that leaves RUN.
                RUN: begin
                    if (i_halt || (i_rx_done && i_rx_data == CMD_STOP)) begin
                        o_mips_enable <= 1'b0;
                        state         <= CAPTURE;
                    end
                end

                STEP: begin
                    o_mips_enable <= 1'b0;
                    state         <= CAPTURE;
                end

                CAPTURE: begin
                    snapshot <= {cycles, i_if_id, i_id_ex, i_ex_mem, i_mem_wb};
                    byte_idx <= '0;
                    state    <= SEND;
                end

                // The snapshot shifts left per byte, so the top byte is always the next to send.
                SEND: begin
                    o_tx_data  <= snapshot[SNAP_W-1 -: NB_DATA];
                    o_tx_start <= 1'b1;
                    state      <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (i_tx_done) begin
                        if (byte_idx == IDX_W'(NB_BYTES - 1)) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                            snapshot <= snapshot << NB_DATA;
                            state    <= SEND;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_debug_unit.sv
// Self-checking bench for mips_debug_unit: randomized latch contents and transmitter delays against a snapshot model.
module tb_mips_debug_unit;

    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_STOP = 8'h50;
    localparam int         BUDGET   = 5000;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_done;
    logic         tx_done;
    logic         halt;
    logic [63:0]  if_id;
    logic [191:0] id_ex;
    logic [127:0] ex_mem;
    logic [63:0]  mem_wb;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         mips_enable;
    logic         busy;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           en_cnt  = 0;
    logic [7:0]   got[$];
    logic [31:0]  model_cycles;

    mips_debug_unit dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .i_halt       (halt),
        .i_if_id      (if_id),
        .i_id_ex      (id_ex),
        .i_ex_mem     (ex_mem),
        .i_mem_wb     (mem_wb),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_mips_enable(mips_enable),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Count enabled cycles as seen by the pipeline.
    initial forever begin
        @(negedge clk);
        if (mips_enable) en_cnt++;
    end

    // Transmitter model: records each requested byte and finishes it after a random delay.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                got.push_back(tx_data);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    function automatic logic [479:0] exp_snap(input logic [31:0] c);
        return {c, if_id, id_ex, ex_mem, mem_wb};
    endfunction

    task automatic randomize_latches();
        if_id  = {$urandom, $urandom};
        id_ex  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ex_mem = {$urandom, $urandom, $urandom, $urandom};
        mem_wb = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        rx_done = 1'b0;
        halt    = 1'b0;
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        model_cycles = 32'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_dump(input int base, output bit ok);
        int t = 0;
        while (!(got.size() - base >= 60 && !busy) && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        ok = (t < BUDGET);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({tx_data, tx_start, mips_enable, busy} !== 11'd0) begin
            $display("FAIL reset_outputs got=%h want=000", {tx_data, tx_start, mips_enable, busy});
            n_fail++;
        end
    endtask

    task automatic test_step();
        int base = got.size();
        int eb   = en_cnt;
        int bad  = 0;
        bit ok;
        logic [479:0] e;
        do_reset();
        base = got.size();
        eb   = en_cnt;
        if_id = {8{8'hA5}}; id_ex = {24{8'hA5}}; ex_mem = {16{8'hA5}}; mem_wb = {8{8'hA5}};
        send_rx(CMD_STEP);
        n_tests++;
        if (busy !== 1'b1) begin
            $display("FAIL step_busy_rise got=%b want=1", busy);
            n_fail++;
        end
        wait_dump(base, ok);
        model_cycles += 1;
        e = exp_snap(model_cycles);
        n_tests++;
        if (!ok) begin
            $display("FAIL step_timeout got=%0d bytes want=60", got.size() - base);
            n_fail++;
        end
        n_tests++;
        if (en_cnt - eb !== 1) begin
            $display("FAIL step_enable_cycles got=%0d want=1", en_cnt - eb);
            n_fail++;
        end
        n_tests++;
        if ({got[base], got[base+1], got[base+2], got[base+3]} !== 32'h0000_0001) begin
            $display("FAIL step_counter got=%h want=00000001",
                     {got[base], got[base+1], got[base+2], got[base+3]});
            n_fail++;
        end
        for (int i = 0; i < 60; i++) if (got[base+i] !== e[479-8*i -: 8]) bad++;
        n_tests++;
        if (bad != 0 || busy !== 1'b0) begin
            $display("FAIL step_dump bad_bytes=%0d busy=%b want 0 bad and busy 0", bad, busy);
            n_fail++;
        end
    endtask

    task automatic test_run_halt(input int k, input bit with_stop);
        int base;
        int eb;
        int bad = 0;
        bit ok;
        logic [479:0] e;
        do_reset();
        randomize_latches();
        base = got.size();
        eb   = en_cnt;
        send_rx(CMD_RUN);
        repeat (k - 1) @(negedge clk);
        halt = 1'b1;
        if (with_stop) send_rx(CMD_STOP);
        wait_dump(base, ok);
        halt = 1'b0;
        repeat (30) @(negedge clk);
        model_cycles += 32'(k);
        e = exp_snap(model_cycles);
        n_tests++;
        if (!ok || got.size() - base != 60) begin
            $display("FAIL run_byte_count k=%0d stop=%0b got=%0d want=60", k, with_stop, got.size() - base);
            n_fail++;
        end
        n_tests++;
        if (en_cnt - eb !== k) begin
            $display("FAIL run_enable_cycles got=%0d want=%0d", en_cnt - eb, k);
            n_fail++;
        end
        for (int i = 0; i < 60; i++) if (got[base+i] !== e[479-8*i -: 8]) bad++;
        n_tests++;
        if (bad != 0) begin
            $display("FAIL run_dump k=%0d counter=%h want=%h bad_bytes=%0d", k,
                     {got[base], got[base+1], got[base+2], got[base+3]}, model_cycles, bad);
            n_fail++;
        end
    endtask

    task automatic test_halt_preset();
        int base;
        int eb;
        bit ok;
        do_reset();
        randomize_latches();
        base = got.size();
        eb   = en_cnt;
        halt = 1'b1;
        send_rx(CMD_RUN);
        wait_dump(base, ok);
        halt = 1'b0;
        n_tests++;
        if (!ok || en_cnt - eb !== 1 ||
            {got[base], got[base+1], got[base+2], got[base+3]} !== 32'd1) begin
            $display("FAIL halt_preset enable=%0d counter=%h want enable=1 counter=00000001",
                     en_cnt - eb, {got[base], got[base+1], got[base+2], got[base+3]});
            n_fail++;
        end
    endtask

    task automatic test_dump();
        int base;
        int eb;
        int bad = 0;
        bit ok;
        logic [479:0] e;
        do_reset();
        randomize_latches();
        if_id = 64'h0123_4567_89AB_CDEF;
        base  = got.size();
        eb    = en_cnt;
        send_rx(CMD_DUMP);
        wait_dump(base, ok);
        n_tests++;
        if (!ok || en_cnt - eb !== 0) begin
            $display("FAIL dump_no_enable enable=%0d ok=%0b want enable=0", en_cnt - eb, ok);
            n_fail++;
        end
        n_tests++;
        if ({got[base+4], got[base+5], got[base+6], got[base+7],
             got[base+8], got[base+9], got[base+10], got[base+11]} !== 64'h0123_4567_89AB_CDEF) begin
            $display("FAIL dump_if_id got=%h want=0123456789abcdef",
                     {got[base+4], got[base+5], got[base+6], got[base+7],
                      got[base+8], got[base+9], got[base+10], got[base+11]});
            n_fail++;
        end
        e = exp_snap(model_cycles);
        for (int i = 0; i < 60; i++) if (got[base+i] !== e[479-8*i -: 8]) bad++;
        n_tests++;
        if (bad != 0) begin
            $display("FAIL dump_snapshot bad_bytes=%0d want=0", bad);
            n_fail++;
        end
    endtask

    task automatic test_ignored();
        int base;
        int eb;
        int t = 0;
        int bad = 0;
        bit ok;
        logic [479:0] e;
        do_reset();
        randomize_latches();
        base = got.size();
        eb   = en_cnt;
        send_rx(8'h00);
        repeat (5) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || en_cnt - eb !== 0 || got.size() != base) begin
            $display("FAIL idle_ignore busy=%b enable=%0d bytes=%0d want 0 0 0",
                     busy, en_cnt - eb, got.size() - base);
            n_fail++;
        end
        send_rx(CMD_STEP);
        while (got.size() - base < 3 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        send_rx(CMD_STEP);
        send_rx(CMD_RUN);
        wait_dump(base, ok);
        repeat (40) @(negedge clk);
        model_cycles += 1;
        e = exp_snap(model_cycles);
        for (int i = 0; i < 60; i++) if (got[base+i] !== e[479-8*i -: 8]) bad++;
        n_tests++;
        if (!ok || en_cnt - eb !== 1 || got.size() - base != 60 || bad != 0) begin
            $display("FAIL busy_ignore enable=%0d bytes=%0d bad=%0d want enable=1 bytes=60 bad=0",
                     en_cnt - eb, got.size() - base, bad);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_dump();
        int base;
        int t = 0;
        bit ok;
        do_reset();
        randomize_latches();
        base = got.size();
        send_rx(CMD_STEP);
        while (got.size() - base < 21 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (t >= BUDGET || {tx_data, tx_start, mips_enable, busy} !== 11'd0) begin
            $display("FAIL reset_mid_dump got=%h want=000 timeout=%0b",
                     {tx_data, tx_start, mips_enable, busy}, t >= BUDGET);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        model_cycles = 32'd0;
        repeat (6) @(negedge clk);
        base = got.size();
        send_rx(CMD_STEP);
        wait_dump(base, ok);
        n_tests++;
        if (!ok || {got[base], got[base+1], got[base+2], got[base+3]} !== 32'd1) begin
            $display("FAIL reset_then_step counter=%h want=00000001",
                     {got[base], got[base+1], got[base+2], got[base+3]});
            n_fail++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        halt    = 1'b0;
        if_id   = '0;
        id_ex   = '0;
        ex_mem  = '0;
        mem_wb  = '0;
        test_reset();
        test_step();
        test_run_halt(11, 1'b0);
        test_run_halt($urandom_range(1, 25), 1'b0);
        test_run_halt($urandom_range(2, 25), 1'b1);
        test_halt_preset();
        test_dump();
        test_ignored();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
